// File: rtl/spmm_pkg.sv
// Shared types and helpers for the SpMM reduction datapath.
// SATURATE_EN: when defined, provides sat_add for clamping stage adds.
package spmm_pkg;

  localparam int N_DEF = 16;
  localparam int W_DEF = 8;

  typedef logic [W_DEF-1:0] data_t;

`ifdef SATURATE_EN
  // Unsigned add of two w-bit operands (zero-extended to 64 bits),
  // clamped to 2^w-1 when the true sum does not fit in w bits.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int unsigned w);
    logic [64:0] sum;
    logic [63:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    if (sum > {1'b0, lim}) begin
      sat_add = lim;
    end else begin
      sat_add = sum[63:0];
    end
  endfunction
`endif

endpackage

// File: rtl/seg_reduce_pipe_if.sv
// Handshake bundle for seg_reduce_pipe: input vector side, result side and
// the occupancy status. slave is the unit's view, master the driver's view.
interface seg_reduce_pipe_if #(
  parameter int N = 16,
  parameter int W = 8
);
  localparam int LGN = $clog2(N);
  localparam int OCW = $clog2(LGN + 2);

  logic             in_valid;
  logic             in_ready;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_split;
  logic [N*LGN-1:0] in_idx;
  logic             out_valid;
  logic             out_ready;
  logic [N*W-1:0]   out_data;
  logic [OCW-1:0]   occupancy;

  modport slave (
    input  in_valid, in_data, in_split, in_idx, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );

  modport master (
    output in_valid, in_data, in_split, in_idx, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

endinterface

// File: rtl/seg_reduce_pipe_stage.sv
// seg_scan_stage: one Hillis-Steele step of the segmented scan.
// Lane i >= DIST that is not yet closed by a head flag absorbs lane i-DIST;
// the result is registered with a hold enable and a valid bit.
// SATURATE_EN: when defined, each add clamps to 2^W-1 instead of wrapping.
module seg_scan_stage
  import spmm_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int W    = W_DEF,
  parameter int DIST = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     adv,
  input  logic                     valid_in,
  input  logic [N*W-1:0]           v_in,
  input  logic [N-1:0]             f_in,
  input  logic [N*$clog2(N)-1:0]   idx_in,
  output logic                     valid_out,
  output logic [N*W-1:0]           v_out,
  output logic [N-1:0]             f_out,
  output logic [N*$clog2(N)-1:0]   idx_out
);

  logic [N*W-1:0] v_nxt;
  logic [N-1:0]   f_nxt;
  logic [W-1:0]   a_op;
  logic [W-1:0]   b_op;
  logic [W-1:0]   s_op;

`ifdef SATURATE_EN
  logic [63:0] sat_wide;
  logic        unused_sat_hi;
  assign unused_sat_hi = ^sat_wide[63:W];
`endif

  // Combine each open lane with its partner DIST lanes below.
  always_comb begin
    v_nxt = v_in;
    f_nxt = f_in;
    a_op  = '0;
    b_op  = '0;
    s_op  = '0;
`ifdef SATURATE_EN
    sat_wide = '0;
`endif
    for (int i = DIST; i < N; i++) begin
      if (!f_in[i]) begin
        a_op = v_in[(i-DIST)*W +: W];
        b_op = v_in[i*W +: W];
`ifdef SATURATE_EN
        sat_wide = sat_add(64'(a_op), 64'(b_op), W);
        s_op     = sat_wide[W-1:0];
`else
        s_op = a_op + b_op;
`endif
        v_nxt[i*W +: W] = s_op;
        f_nxt[i]        = f_in[i-DIST];
      end
    end
  end

  // Stage register: loads when downstream can take it, otherwise holds.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_out <= 1'b0;
      v_out     <= '0;
      f_out     <= '0;
      idx_out   <= '0;
    end else if (adv) begin
      valid_out <= valid_in;
      v_out     <= v_nxt;
      f_out     <= f_nxt;
      idx_out   <= idx_in;
    end
  end

endmodule

// File: rtl/seg_reduce_pipe.sv
// seg_reduce_pipe: pipelined segmented inclusive prefix sum over N lanes in
// log2(N) registered scan stages, followed by a registered gather of N
// selected partial sums. Valid/ready on both sides with bubble collapse.
// SATURATE_EN: when defined, stage adds saturate at 2^W-1 (ports unchanged).
module seg_reduce_pipe
  import spmm_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input logic           clock,
  input logic           reset,
  seg_reduce_pipe_if.slave bus
);

  localparam int LGN = $clog2(N);
  localparam int OCW = $clog2(LGN + 2);

  // Index 0 is the input side; index k+1 is the output of scan stage k.
  logic [LGN:0]                valid_pipe;
  logic [LGN:0][N*W-1:0]       v_pipe;
  logic [LGN:0][N-1:0]         f_pipe;
  logic [LGN:0][N*LGN-1:0]     idx_pipe;

  logic [LGN-1:0] adv;
  logic           adv_last;
  logic           all_full;
  logic [N-1:0]   head;

  logic           out_valid_q;
  logic [N*W-1:0] out_data_q;
  logic [N*W-1:0] gather;
  logic [LGN-1:0] sel;
  logic [OCW-1:0] occ;

  // Lane 0 always opens a segment; the last split bit has no lane after it.
  assign head = {bus.in_split[N-2:0], 1'b1};

  logic unused_ok;
  assign unused_ok = ^{bus.in_split[N-1], f_pipe[LGN]};

  assign valid_pipe[0] = bus.in_valid;
  assign v_pipe[0]     = bus.in_data;
  assign f_pipe[0]     = head;
  assign idx_pipe[0]   = bus.in_idx;

  for (genvar k = 0; k < LGN; k++) begin : g_stage
    seg_scan_stage #(
      .N   (N),
      .W   (W),
      .DIST(1 << k)
    ) u_stage (
      .clock    (clock),
      .reset    (reset),
      .adv      (adv[k]),
      .valid_in (valid_pipe[k]),
      .v_in     (v_pipe[k]),
      .f_in     (f_pipe[k]),
      .idx_in   (idx_pipe[k]),
      .valid_out(valid_pipe[k+1]),
      .v_out    (v_pipe[k+1]),
      .f_out    (f_pipe[k+1]),
      .idx_out  (idx_pipe[k+1])
    );
  end

  assign adv_last = !out_valid_q || bus.out_ready;

  // Ready chain: stage k advances if the output drains or any stage from k
  // to the end is empty (that hole lets everything upstream of it shift).
  always_comb begin
    adv      = '0;
    all_full = 1'b1;
    for (int k = LGN - 1; k >= 0; k--) begin
      all_full = all_full & valid_pipe[k+1];
      adv[k]   = adv_last | ~all_full;
    end
  end

  assign bus.in_ready = adv[0];

  // Gather: output lane j picks the partial sum addressed by its index.
  always_comb begin
    gather = '0;
    sel    = '0;
    for (int j = 0; j < N; j++) begin
      sel                 = idx_pipe[LGN][j*LGN +: LGN];
      gather[j*W +: W]    = v_pipe[LGN][int'(sel)*W +: W];
    end
  end

  // Output register: data only changes when a valid vector is taken.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (adv_last) begin
      out_valid_q <= valid_pipe[LGN];
      if (valid_pipe[LGN]) begin
        out_data_q <= gather;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  // Occupancy: scan stages holding a vector plus the output register.
  always_comb begin
    occ = '0;
    for (int k = 1; k <= LGN; k++) begin
      occ = occ + OCW'(valid_pipe[k]);
    end
    occ = occ + OCW'(out_valid_q);
  end

  assign bus.occupancy = occ;

endmodule

// File: tb/tb_seg_reduce_pipe.sv
// Bench for seg_reduce_pipe: an N=4 instance driven from a table of
// hand-computed vectors, and an N=16 instance for streaming, stall,
// bubble and mid-stream reset sequences checked against a reference model.
module tb_seg_reduce_pipe;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  seg_reduce_pipe_if #(.N(4),  .W(8)) if4 ();
  seg_reduce_pipe_if #(.N(16), .W(8)) if16 ();

  seg_reduce_pipe #(.N(4), .W(8)) dut4 (
    .clock(clock),
    .reset(reset),
    .bus  (if4.slave)
  );

  seg_reduce_pipe #(.N(16), .W(8)) dut16 (
    .clock(clock),
    .reset(reset),
    .bus  (if16.slave)
  );

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  split;
    logic [7:0]  idx;
    logic [31:0] exp;
  } vec4_t;

  typedef struct {
    logic [127:0] data;
    int           cyc;
  } exp_t;

  vec4_t tbl[8];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Straight sequential segmented sum, then gather.
  function automatic logic [127:0] model16(input logic [127:0] d, input logic [15:0] s,
                                           input logic [63:0] ix);
    logic [7:0] ps [16];
    logic [8:0] t;
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (i == 0) begin
        ps[i] = d[7:0];
      end else if (s[i-1]) begin
        ps[i] = d[i*8 +: 8];
      end else begin
        t = {1'b0, ps[i-1]} + {1'b0, d[i*8 +: 8]};
`ifdef SATURATE_EN
        ps[i] = t[8] ? 8'hFF : t[7:0];
`else
        ps[i] = t[7:0];
`endif
      end
    end
    for (int j = 0; j < 16; j++) r[j*8 +: 8] = ps[ix[j*4 +: 4]];
    return r;
  endfunction

  task automatic new_vec(output logic [127:0] d, output logic [15:0] s, output logic [63:0] ix);
    d  = {$urandom, $urandom, $urandom, $urandom};
    s  = 16'($urandom) & 16'($urandom);
    ix = {$urandom, $urandom};
  endtask

  // One N=4 vector: push, measure latency to out_valid, compare result.
  task automatic apply4(input int n);
    int lat;
    @(negedge clock);
    if4.in_valid = 1'b1;
    if4.in_data  = tbl[n].data;
    if4.in_split = tbl[n].split;
    if4.in_idx   = tbl[n].idx;
    #1;
    check($sformatf("v%0d_in_ready", n), 128'(if4.in_ready), 128'(1));
    @(posedge clock);
    #1;
    if4.in_valid = 1'b0;
    lat = 1;
    while (!if4.out_valid && lat < 20) begin
      @(posedge clock);
      #1;
      lat++;
    end
    check($sformatf("v%0d_latency", n), 128'(lat), 128'(3));
    check($sformatf("v%0d_out_data", n), 128'(if4.out_data), 128'(tbl[n].exp));
  endtask

  // mode 0: backpressure window, mode 1: bubbles + random out_ready,
  // mode 2: free-running with latency check.
  task automatic run_stream(input int nvec, input int mode);
    exp_t         q[$];
    exp_t         e;
    int           pushed, popped, cyc, max_occ, exp_occ;
    bit           prev_stall;
    logic [127:0] prev_data;
    logic [127:0] cur_d;
    logic [15:0]  cur_s;
    logic [63:0]  cur_i;
    pushed = 0; popped = 0; cyc = 0; max_occ = 0;
    prev_stall = 1'b0; prev_data = '0;
    new_vec(cur_d, cur_s, cur_i);
    while ((pushed < nvec || popped < nvec) && cyc < 300) begin
      @(negedge clock);
      if16.in_valid = (pushed < nvec) && (mode != 1 || cyc % 2 == 0);
      if16.in_data  = cur_d;
      if16.in_split = cur_s;
      if16.in_idx   = cur_i;
      case (mode)
        0:       if16.out_ready = !(cyc >= 3 && cyc <= 10);
        1:       if16.out_ready = 1'($urandom_range(0, 1));
        default: if16.out_ready = 1'b1;
      endcase
      #1;
      if (prev_stall) begin
        check("stall_valid", 128'(if16.out_valid), 128'(1));
        check("stall_hold", if16.out_data, prev_data);
      end
      if (mode == 0) begin
        exp_occ = (cyc < 5) ? cyc : (cyc <= 14) ? 5 : 19 - cyc;
        check($sformatf("bp_occ_c%0d", cyc), 128'(if16.occupancy), 128'(exp_occ));
        check($sformatf("bp_in_ready_c%0d", cyc), 128'(if16.in_ready),
              128'(!(cyc >= 5 && cyc <= 10)));
      end
      if (int'(if16.occupancy) > max_occ) max_occ = int'(if16.occupancy);
      if (if16.out_valid && if16.out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_out", 128'(q.size()), 128'(1));
        end else begin
          e = q.pop_front();
          check($sformatf("m%0d_out%0d", mode, popped), if16.out_data, e.data);
          if (mode == 2) check("latency16", 128'(cyc - e.cyc), 128'(5));
        end
        popped++;
      end
      prev_stall = if16.out_valid && !if16.out_ready;
      prev_data  = if16.out_data;
      if (if16.in_valid && if16.in_ready) begin
        e.data = model16(cur_d, cur_s, cur_i);
        e.cyc  = cyc;
        q.push_back(e);
        pushed++;
        new_vec(cur_d, cur_s, cur_i);
      end
      cyc++;
    end
    @(negedge clock);
    if16.in_valid  = 1'b0;
    if16.out_ready = 1'b1;
    check($sformatf("m%0d_done_in_budget", mode), 128'(cyc < 300), 128'(1));
    check($sformatf("m%0d_max_occ", mode), 128'(max_occ <= 5), 128'(1));
    check($sformatf("m%0d_popped", mode), 128'(popped), 128'(nvec));
    check($sformatf("m%0d_queue_empty", mode), 128'(q.size()), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] d;
    logic [15:0]  s;
    logic [63:0]  ix;

    tbl[0] = '{32'h04030201, 4'b0000, 8'h1B, 32'h0103060A};
    tbl[1] = '{32'h04030201, 4'b0010, 8'hE4, 32'h07030301};
    tbl[2] = '{32'h04030201, 4'b1111, 8'hE4, 32'h04030201};
`ifdef SATURATE_EN
    tbl[3] = '{32'h000064C8, 4'b0000, 8'h55, 32'hFFFFFFFF};
`else
    tbl[3] = '{32'h000064C8, 4'b0000, 8'h55, 32'h2C2C2C2C};
`endif
    tbl[4] = '{32'h08070605, 4'b1000, 8'hE4, 32'h1A120B05};
    tbl[5] = '{32'h281E140A, 4'b0001, 8'h8F, 32'h320A5A5A};
    tbl[6] = '{32'h01010101, 4'b0100, 8'hE4, 32'h01030201};
`ifdef SATURATE_EN
    tbl[7] = '{32'hFFFFFFFF, 4'b0000, 8'hE4, 32'hFFFFFFFF};
`else
    tbl[7] = '{32'hFFFFFFFF, 4'b0000, 8'hE4, 32'hFCFDFEFF};
`endif

    if4.in_valid  = 1'b0; if4.in_data  = '0; if4.in_split  = '0; if4.in_idx  = '0;
    if4.out_ready = 1'b1;
    if16.in_valid = 1'b0; if16.in_data = '0; if16.in_split = '0; if16.in_idx = '0;
    if16.out_ready = 1'b1;

    #1;
    check("rst_out_valid16", 128'(if16.out_valid), 128'(0));
    check("rst_occ16", 128'(if16.occupancy), 128'(0));
    check("rst_out_data16", if16.out_data, 128'(0));
    check("rst_out_valid4", 128'(if4.out_valid), 128'(0));
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("post_rst_in_ready16", 128'(if16.in_ready), 128'(1));
    check("post_rst_in_ready4", 128'(if4.in_ready), 128'(1));

    for (int n = 0; n < 8; n++) apply4(n);

    run_stream(8, 0);
    run_stream(12, 1);

    // Mid-stream reset with the output register and 3 stages occupied.
    for (int p = 0; p < 4; p++) begin
      @(negedge clock);
      new_vec(d, s, ix);
      if16.out_ready = 1'b0;
      if16.in_valid  = 1'b1;
      if16.in_data   = d;
      if16.in_split  = s;
      if16.in_idx    = ix;
    end
    @(negedge clock);
    if16.in_valid = 1'b0;
    @(negedge clock);
    #1;
    check("pre_reset_valid", 128'(if16.out_valid), 128'(1));
    check("pre_reset_occ", 128'(if16.occupancy), 128'(4));
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid", 128'(if16.out_valid), 128'(0));
    check("mid_rst_occ", 128'(if16.occupancy), 128'(0));
    check("mid_rst_out_data", if16.out_data, 128'(0));
    @(negedge clock);
    reset = 1'b0;
    if16.out_ready = 1'b1;
    @(posedge clock);
    #1;
    check("rel_in_ready", 128'(if16.in_ready), 128'(1));
    check("rel_out_valid", 128'(if16.out_valid), 128'(0));

    run_stream(1, 2);
    run_stream(4, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
